// File: rtl/bit_serializer_if.sv
// bit_serializer_if: word handshake and serial-stream signals of the bit serializer.
interface bit_serializer_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             flush;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_done;
    logic             busy;
    modport master (output din, din_valid, flush, input din_ready, ser_out, ser_valid, frame_done, busy);
    modport slave  (input din, din_valid, flush, output din_ready, ser_out, ser_valid, frame_done, busy);
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer: shifts WIDTH-bit words out one bit per clock with gapless back-to-back framing.
module bit_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    bit_serializer_if.slave  s
);
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam int CW = $clog2(WIDTH);
    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_sr, w_sr_nx;
    logic [CW-1:0]    r_cnt, w_cnt_nx;
    logic             r_ser_out, w_ser_out_nx;
    logic             r_ser_valid, w_ser_valid_nx;
    logic             w_last, w_ready, w_accept;
    assign w_last   = r_cnt == '0;
    assign w_ready  = !s.flush && (r_state == IDLE || w_last);
    assign w_accept = s.din_valid && w_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_ser_out   <= IDLE_LEVEL;
            r_ser_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_sr        <= w_sr_nx;
            r_cnt       <= w_cnt_nx;
            r_ser_out   <= w_ser_out_nx;
            r_ser_valid <= w_ser_valid_nx;
        end
    end
    // Flush outranks accept; a load on the last bit keeps the stream gapless.
    always_comb begin
        w_state_nx     = r_state;
        w_sr_nx        = r_sr;
        w_cnt_nx       = r_cnt;
        w_ser_out_nx   = r_ser_out;
        w_ser_valid_nx = r_ser_valid;
        if (s.flush || (r_state == SHIFT && w_last && !w_accept)) begin
            w_state_nx     = IDLE;
            w_cnt_nx       = '0;
            w_ser_out_nx   = IDLE_LEVEL;
            w_ser_valid_nx = 1'b0;
        end else if (w_accept) begin
            w_state_nx     = SHIFT;
            w_sr_nx        = s.din;
            w_cnt_nx       = CW'(WIDTH - 1);
            w_ser_out_nx   = MSB_FIRST ? s.din[WIDTH-1] : s.din[0];
            w_ser_valid_nx = 1'b1;
        end else if (r_state == SHIFT) begin
            w_sr_nx      = MSB_FIRST ? r_sr << 1 : r_sr >> 1;
            w_ser_out_nx = MSB_FIRST ? r_sr[WIDTH-2] : r_sr[1];
            w_cnt_nx     = r_cnt - CW'(1);
        end
    end
    assign s.din_ready  = w_ready;
    assign s.ser_out    = r_ser_out;
    assign s.ser_valid  = r_ser_valid;
    assign s.frame_done = r_ser_valid && w_last;
    assign s.busy       = r_state == SHIFT;
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: MSB-first and LSB-first serializers checked against per-instance bit-queue models.
module tb_bit_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   det_cnt = 0;
    logic qm[$];
    logic ql[$];
    logic [2:0] hist;
    logic det;
    bit_serializer_if #(8) im();
    bit_serializer_if #(8) il();
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_m (.clk(clk), .rst_n(rst_n), .s(im));
    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_l (.clk(clk), .rst_n(rst_n), .s(il));
    always #5 clk = ~clk;
    // Behavioural 101 Moore detector listening to the MSB-first stream.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 3'b0;
            det  <= 1'b0;
        end else begin
            hist <= im.ser_valid ? {hist[1:0], im.ser_out} : 3'b0;
            det  <= im.ser_valid && {hist[1:0], im.ser_out} == 3'b101;
        end
    end
    task automatic chk(input string tag, input logic o, input logic e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, o, e);
        end
    endtask
    task automatic step(input logic v, input logic [7:0] d, input logic f);
        logic rdy;
        @(negedge clk);
        im.din = d; il.din = d;
        im.din_valid = v; il.din_valid = v;
        im.flush = f; il.flush = f;
        #1;
        rdy = !f && qm.size() <= 1;
        chk("m_valid", im.ser_valid, qm.size() > 0);
        chk("m_out", im.ser_out, qm.size() > 0 ? qm[0] : 1'b0);
        chk("m_done", im.frame_done, qm.size() == 1);
        chk("m_busy", im.busy, qm.size() > 0);
        chk("m_ready", im.din_ready, rdy);
        chk("l_valid", il.ser_valid, ql.size() > 0);
        chk("l_out", il.ser_out, ql.size() > 0 ? ql[0] : 1'b0);
        chk("l_done", il.frame_done, ql.size() == 1);
        chk("l_busy", il.busy, ql.size() > 0);
        chk("l_ready", il.din_ready, !f && ql.size() <= 1);
        if (det) det_cnt++;
        if (f) begin
            qm.delete();
            ql.delete();
        end else begin
            if (qm.size() > 0) void'(qm.pop_front());
            if (ql.size() > 0) void'(ql.pop_front());
            if (v && rdy)
                for (int i = 0; i < 8; i++) begin
                    qm.push_back(d[7-i]);
                    ql.push_back(d[i]);
                end
        end
    endtask
    initial begin
        im.din = '0; il.din = '0;
        im.din_valid = 1'b0; il.din_valid = 1'b0;
        im.flush = 1'b0; il.flush = 1'b0;
        #12;
        chk("rst_valid", im.ser_valid, 1'b0);
        chk("rst_out", im.ser_out, 1'b0);
        chk("rst_busy", im.busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", im.din_ready, 1'b1);
        step(1'b1, 8'hA5, 1'b0);
        repeat (10) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hF0, 1'b0);
        repeat (7) step(1'b1, 8'hF0, 1'b0);
        repeat (18) step(1'b1, 8'h0F, 1'b0);
        repeat (10) step(1'b0, 8'h0F, 1'b0);
        step(1'b1, 8'h01, 1'b0);
        repeat (10) step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h80, 1'b1);
        step(1'b1, 8'h80, 1'b0);
        repeat (10) step(1'b0, 8'h00, 1'b0);
        det_cnt = 0;
        step(1'b1, 8'b0101_0000, 1'b0);
        repeat (12) step(1'b0, 8'h00, 1'b0);
        checks++;
        assert (det_cnt == 1) else begin
            errors++;
            $error("FAIL det_pulses observed=%0d expected=1", det_cnt);
        end
        step(1'b1, 8'h3C, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", im.ser_valid, 1'b0);
        chk("arst_out", im.ser_out, 1'b0);
        chk("arst_busy", im.busy, 1'b0);
        chk("arst_l_valid", il.ser_valid, 1'b0);
        qm.delete();
        ql.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_ready", im.din_ready, 1'b1);
        for (int n = 0; n < 400; n++)
            step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 15) == 0));
        repeat (10) step(1'b0, 8'h00, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
